// File: rtl/fsm_ctrl.sv
// Flow-control state machine for the four-FIFO TLP datapath.
// Aggregates FIFO status into idle, pause, continue and sticky error/full.
module fsm_ctrl (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_init,
  input  logic       i_FIFOpause0,
  input  logic       i_FIFOpause1,
  input  logic       i_FIFOpause2,
  input  logic       i_FIFOpause3,
  input  logic       i_FIFOcontinue0,
  input  logic       i_FIFOcontinue1,
  input  logic       i_FIFOcontinue2,
  input  logic       i_FIFOcontinue3,
  input  logic       i_FIFOempty0,
  input  logic       i_FIFOempty1,
  input  logic       i_FIFOempty2,
  input  logic       i_FIFOempty3,
  input  logic       i_FIFOerror0,
  input  logic       i_FIFOerror1,
  input  logic       i_FIFOerror2,
  input  logic       i_FIFOerror3,
  input  logic       i_FIFOfull0,
  input  logic       i_FIFOfull1,
  input  logic       i_FIFOfull2,
  input  logic       i_FIFOfull3,
  output logic [3:0] o_error_full,
  output logic [3:0] o_pause,
  output logic [3:0] o_continue,
  output logic       o_idle
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_pause_v;
  logic [3:0] w_cont_v;
  logic [3:0] w_empty_v;
  logic [3:0] w_errfull_v;
  logic       w_any_err;
  logic       w_any_pause;
  logic       w_all_empty;
  logic [3:0] w_ef_nxt;
  logic [3:0] w_pause_nxt;
  logic [3:0] w_cont_nxt;
  logic       w_idle_nxt;

  assign w_pause_v   = {i_FIFOpause3, i_FIFOpause2,
                        i_FIFOpause1, i_FIFOpause0};
  assign w_cont_v    = {i_FIFOcontinue3, i_FIFOcontinue2,
                        i_FIFOcontinue1, i_FIFOcontinue0};
  assign w_empty_v   = {i_FIFOempty3, i_FIFOempty2,
                        i_FIFOempty1, i_FIFOempty0};
  assign w_errfull_v = {i_FIFOerror3 | i_FIFOfull3,
                        i_FIFOerror2 | i_FIFOfull2,
                        i_FIFOerror1 | i_FIFOfull1,
                        i_FIFOerror0 | i_FIFOfull0};
  assign w_any_err   = |w_errfull_v;
  assign w_any_pause = |w_pause_v;
  assign w_all_empty = &w_empty_v;

  // Next-state selection; init overrides everything, bad codes recover via INIT
  always_comb begin
    w_next = ST_INIT;
    if (!i_init) begin
      case (r_state)
        ST_RESET: w_next = ST_INIT;
        ST_INIT:  w_next = ST_IDLE;
        ST_IDLE: begin
          if (w_any_err)         w_next = ST_ERROR;
          else if (!w_all_empty) w_next = ST_ACTIVE;
          else                   w_next = ST_IDLE;
        end
        ST_ACTIVE: begin
          if (w_any_err)        w_next = ST_ERROR;
          else if (w_any_pause) w_next = ST_PAUSE;
          else if (w_all_empty) w_next = ST_IDLE;
          else                  w_next = ST_ACTIVE;
        end
        ST_PAUSE: begin
          if (w_any_err)        w_next = ST_ERROR;
          else if (w_any_pause) w_next = ST_PAUSE;
          else                  w_next = ST_ACTIVE;
        end
        ST_ERROR: w_next = ST_ERROR;
        default:  w_next = ST_INIT;
      endcase
    end
  end

  // Output values to be registered, derived from the upcoming state
  always_comb begin
    w_idle_nxt  = 1'b0;
    w_pause_nxt = 4'd0;
    w_cont_nxt  = 4'd0;
    w_ef_nxt    = 4'd0;
    case (w_next)
      ST_IDLE: begin
        w_idle_nxt = 1'b1;
        w_ef_nxt   = o_error_full | w_errfull_v;
      end
      ST_ACTIVE, ST_PAUSE: begin
        w_pause_nxt = w_pause_v;
        w_cont_nxt  = w_cont_v;
        w_ef_nxt    = o_error_full | w_errfull_v;
      end
      ST_ERROR: w_ef_nxt = o_error_full | w_errfull_v;
      default: ;
    endcase
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_RESET;
      o_error_full <= 4'd0;
      o_pause      <= 4'd0;
      o_continue   <= 4'd0;
      o_idle       <= 1'b0;
    end else begin
      r_state      <= w_next;
      o_error_full <= w_ef_nxt;
      o_pause      <= w_pause_nxt;
      o_continue   <= w_cont_nxt;
      o_idle       <= w_idle_nxt;
    end
  end

endmodule

// File: tb/tb_fsm_ctrl.sv
// Testbench for fsm_ctrl: directed vector table, async reset sequence,
// and randomized traffic against a behavioural model.
module tb_fsm_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic [3:0] p = 4'd0, c = 4'd0, e = 4'hF, er = 4'd0, f = 4'd0;
  logic [3:0] ef, pa, co;
  logic       idl;

  int npass = 0;
  int ntot  = 0;

  always #2 clk = ~clk;

  fsm_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_init(init),
    .i_FIFOpause0(p[0]), .i_FIFOpause1(p[1]),
    .i_FIFOpause2(p[2]), .i_FIFOpause3(p[3]),
    .i_FIFOcontinue0(c[0]), .i_FIFOcontinue1(c[1]),
    .i_FIFOcontinue2(c[2]), .i_FIFOcontinue3(c[3]),
    .i_FIFOempty0(e[0]), .i_FIFOempty1(e[1]),
    .i_FIFOempty2(e[2]), .i_FIFOempty3(e[3]),
    .i_FIFOerror0(er[0]), .i_FIFOerror1(er[1]),
    .i_FIFOerror2(er[2]), .i_FIFOerror3(er[3]),
    .i_FIFOfull0(f[0]), .i_FIFOfull1(f[1]),
    .i_FIFOfull2(f[2]), .i_FIFOfull3(f[3]),
    .o_error_full(ef), .o_pause(pa),
    .o_continue(co), .o_idle(idl)
  );

  typedef struct {
    logic       init;
    logic [3:0] p, c, e, er, f;
    logic       x_idle;
    logic [3:0] x_p, x_c, x_ef;
  } vec_t;

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input logic xi,
                         input logic [3:0] xp, xc, xe);
    chk({nm, ".idle"}, {3'd0, idl}, {3'd0, xi});
    chk({nm, ".pause"}, pa, xp);
    chk({nm, ".cont"}, co, xc);
    chk({nm, ".ef"}, ef, xe);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: mode names are the bench's own view of operation
  typedef enum {M_BOOT, M_CLEAR, M_QUIET, M_RUN, M_HOLD, M_FAULT} mode_t;
  mode_t      m_mode;
  logic [3:0] m_ef;

  task automatic model_step(output logic xi, output logic [3:0] xp,
                            output logic [3:0] xc, output logic [3:0] xe);
    mode_t nx;
    logic  bad;
    bad = ((er | f) != 4'd0);
    if (init) nx = M_CLEAR;
    else if (m_mode == M_BOOT) nx = M_CLEAR;
    else if (m_mode == M_CLEAR) nx = M_QUIET;
    else if (m_mode == M_FAULT) nx = M_FAULT;
    else if (bad) nx = M_FAULT;
    else if (m_mode == M_QUIET) nx = (e == 4'hF) ? M_QUIET : M_RUN;
    else if (p != 4'd0) nx = M_HOLD;
    else if (m_mode == M_HOLD) nx = M_RUN;
    else nx = (e == 4'hF) ? M_QUIET : M_RUN;
    if (nx == M_CLEAR) m_ef = 4'd0;
    else m_ef = m_ef | er | f;
    m_mode = nx;
    xi = (nx == M_QUIET);
    xp = (nx == M_RUN || nx == M_HOLD) ? p : 4'd0;
    xc = (nx == M_RUN || nx == M_HOLD) ? c : 4'd0;
    xe = m_ef;
  endtask

  vec_t tbl[$];

  initial begin
    logic xi;
    logic [3:0] xp, xc, xe;

    // init,pause,cont,empty,err,full -> idle,pause,cont,ef
    tbl.push_back('{1, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'hF, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 4'hF, 0, 4'h0, 0, 0, 0, 4'hF, 0, 0});
    tbl.push_back('{0, 0, 4'hF, 4'h0, 0, 0, 0, 0, 4'hF, 0});
    tbl.push_back('{0, 4'h5, 4'hA, 4'h0, 0, 0, 0, 4'h5, 4'hA, 0});
    tbl.push_back('{0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'hF, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 4'hF, 4'h3, 4'h0, 0, 0, 0, 4'hF, 4'h3, 0});
    tbl.push_back('{0, 4'hF, 0, 4'hF, 0, 0, 0, 4'hF, 0, 0});
    tbl.push_back('{0, 4'hF, 4'hF, 4'h0, 4'h1, 0, 0, 0, 0, 4'h1});
    tbl.push_back('{0, 0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 4'h1});
    tbl.push_back('{0, 0, 0, 4'h0, 0, 4'h8, 0, 0, 0, 4'h9});
    tbl.push_back('{1, 0, 0, 4'hF, 4'h2, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'hF, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'hF, 0, 4'h2, 0, 0, 0, 4'h2});

    #3;
    chk_all("reset", 1'b0, 4'd0, 4'd0, 4'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      init = tbl[i].init;
      p = tbl[i].p; c = tbl[i].c; e = tbl[i].e;
      er = tbl[i].er; f = tbl[i].f;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].x_idle,
              tbl[i].x_p, tbl[i].x_c, tbl[i].x_ef);
    end

    // Async reset mid-ERROR: outputs clear without an edge
    f = 4'd0;
    #1;
    reset = 1'b1;
    #0.5;
    chk_all("async_rst", 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    chk_all("rst_hold", 1'b0, 4'd0, 4'd0, 4'd0);
    reset = 1'b0;
    init = 1'b0; e = 4'hF; p = 4'd0; c = 4'd0; er = 4'd0;
    tick();
    chk_all("rst_init", 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    chk_all("rst_idle", 1'b1, 4'd0, 4'd0, 4'd0);

    // Randomized traffic against the model
    m_mode = M_QUIET;
    m_ef = 4'd0;
    for (int n = 0; n < 400; n++) begin
      init = ($urandom_range(0, 19) == 0);
      p  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      c  = 4'($urandom);
      e  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      er = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'd0;
      f  = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'd0;
      model_step(xi, xp, xc, xe);
      tick();
      chk_all($sformatf("rnd%0d", n), xi, xp, xc, xe);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/fsm_ctrl.md
Name: fsm_ctrl

Overview:
- Top-level flow-control state machine for the four-FIFO TLP datapath.
- Watches per-FIFO status flags: pause (almost full), continue (almost empty), empty, error and full.
- Reports aggregate status: idle, per-FIFO pause, per-FIFO continue, and sticky per-FIFO error/full.
- Sits beside the FIFO bank; its outputs drive upstream throttling and the error status register.

Parameters:
- None. Four FIFOs and 4-bit output vectors are fixed.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- init  input  1  synchronous (re)initialization request, active high
- FIFOpause0..FIFOpause3  input  1 each  FIFO n almost-full flag
- FIFOcontinue0..FIFOcontinue3  input  1 each  FIFO n almost-empty / may-resume flag
- FIFOempty0..FIFOempty3  input  1 each  FIFO n empty flag
- FIFOerror0..FIFOerror3  input  1 each  FIFO n overflow/underflow error
- FIFOfull0..FIFOfull3  input  1 each  FIFO n full flag
- error_full  output  4  bit n = sticky (FIFOerrorn | FIFOfulln)
- pause  output  4  bit n = FIFOpausen, registered
- continue  output  4  bit n = FIFOcontinuen, registered
- idle  output  1  high while in IDLE

Behaviour:
- Vector convention: bit n of every vector corresponds to FIFO n; input vectors are formed as {x3,x2,x1,x0}.
- Outputs: all registered, updated on the same edge as the state, so there is 1-cycle latency from input to output.
- States:
  - RESET: entered asynchronously while reset=1.
  - INIT, IDLE, ACTIVE, PAUSE, ERROR: entered on clock edges per the transition rules.
- Asynchronous reset (reset=1): immediately state=RESET, error_full=0, pause=0, continue=0, idle=0. Held while reset is high, including mid-operation.
- Transition priority on each rising edge, with reset low:
  1. init=1 → INIT, from any state, including power-up unknown state. In INIT all outputs are 0 and error_full is cleared.
  2. RESET → INIT.
  3. INIT with init=0 → IDLE.
  4. Any of IDLE/ACTIVE/PAUSE with any FIFOerror or FIFOfull bit set → ERROR.
  5. IDLE: if any FIFOempty bit is 0 → ACTIVE; else stay in IDLE.
  6. ACTIVE: if any FIFOpause bit is 1 → PAUSE; else if all FIFOempty bits are 1 → IDLE; else stay in ACTIVE.
  7. PAUSE: if no FIFOpause bit is set → ACTIVE; else stay in PAUSE.
  8. ERROR: stays in ERROR until reset or init.
- Output rules (registered values per next state):
  - idle <= (next==IDLE).
  - pause <= FIFOpause vector when next is ACTIVE or PAUSE; else 0.
  - continue <= FIFOcontinue vector when next is ACTIVE or PAUSE; else 0.
  - error_full <= error_full | {FIFOerror|FIFOfull} when next is IDLE/ACTIVE/PAUSE/ERROR. It is sticky and cleared only by reset or INIT.
- Simultaneous events:
  - pause and empty both asserted in ACTIVE → PAUSE.
  - error together with pause → ERROR.
  - init together with error → INIT.
- Unused state encodings → INIT on the next edge.

Test Plan:
- Clock period 4. reset=0, init=1, all empty=1, other flags 0; after 1 edge drop init → next edge: idle=1, pause=0, continue=0, error_full=0.
- From IDLE, clear all empty flags → next edge: ACTIVE, idle=0.
- From ACTIVE, set all pause flags → next edge: PAUSE, pause=4'b1111. Then pause=0 with continue all 1 → next edge: ACTIVE, pause=0, continue=4'b1111.
- From ACTIVE, pause vector 4'b0101 and continue vector 4'b1010 → PAUSE, pause=4'b0101, continue=4'b1010.
- Set FIFOerror0=1 → next edge: ERROR, error_full=4'b0001, pause=0, continue=0. Dropping FIFOerror0 leaves error_full=0001 and the state in ERROR.
- Assert reset asynchronously mid-ERROR → outputs go to 0 immediately, without waiting for a clock edge. After release: RESET→INIT→IDLE, with all-empty inputs giving idle=1 two edges later.
